// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch stage.
// State encoding, NOP word and instruction field positions.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int JUMP_LSB = 0;
    localparam int JUMP_MSB = 25;
    localparam int IMM_LSB  = 0;
    localparam int IMM_MSB  = 15;

    // Branch displacement: sign-extended word offset turned into bytes.
    function automatic logic [31:0] branch_disp(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_field_decode.sv
// ifetch_field_decode: extracts the jump field and byte branch offset
// from an instruction word; purely combinational.
module ifetch_field_decode
    import ifetch_pkg::*;
(
    input  logic [31:0] instr,
    output logic [25:0] jump_addr,
    output logic [31:0] branch_addr
);

    // Opcode bits are not part of either field.
    logic unused_opcode;

    assign unused_opcode = ^instr[31:JUMP_MSB+1];
    assign jump_addr     = instr[JUMP_MSB:JUMP_LSB];
    assign branch_addr   = branch_disp(instr[IMM_MSB:IMM_LSB]);

endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: accepts PC addresses, runs imem req/ack, holds IF/ID.
// Define IFETCH_TIMEOUT_EN to bound the wait for imem_ack.
module instr_fetch_stage
    import ifetch_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              pc_valid,
    output logic              pc_ready,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic [25:0]       jump_addr,
    output logic [31:0]       branch_addr,
    output logic              fetch_error
);

    state_t state, state_next;

    logic              busy;
    logic              timeout;
    logic              done;
    logic              ready_raw;
    logic              accept;
    logic [DATA_W-1:0] load_word;
    logic [25:0]       dec_jump;
    logic [31:0]       dec_branch;

    assign busy = (state == WAIT) || (state == DRAIN);

`ifdef IFETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    assign timeout = busy && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

    // Wait counter: restarts on every state change, counts ackless cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state_next != state) begin
            wait_cnt <= '0;
        end else if (busy && !imem_ack) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout            = 1'b0;
`endif

    // A timed-out request counts as complete; a late ack is then ignored.
    assign done      = busy && (imem_ack || timeout);
    assign accept    = pc_valid && pc_ready;
    assign load_word = timeout ? DATA_W'(NOP_INSTR) : imem_rdata;

    ifetch_field_decode u_decode (
        .instr       (load_word),
        .jump_addr   (dec_jump),
        .branch_addr (dec_branch)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush overrides everything except an issued request.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) state_next = WAIT;
            end
            WAIT: begin
                if (flush) begin
                    state_next = done ? IDLE : DRAIN;
                end else if (done) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (!stall) begin
                    state_next = accept ? WAIT : IDLE;
                end
            end
            DRAIN: begin
                if (done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        ready_raw = 1'b0;
        imem_req  = 1'b0;
        unique case (state)
            IDLE:        ready_raw = !flush;
            WAIT, DRAIN: imem_req  = !timeout;
            FULL:        ready_raw = !stall && !flush;
            default:     ready_raw = 1'b0;
        endcase
    end

    assign pc_ready    = ready_raw && !reset;
    assign fetch_error = timeout && (state == WAIT);

    // Request address and IF/ID register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_addr   <= '0;
            instr_out   <= DATA_W'(NOP_INSTR);
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            jump_addr   <= '0;
            branch_addr <= '0;
        end else begin
            if (accept) begin
                imem_addr <= pc_addr;
            end
            if (flush) begin
                instr_out   <= DATA_W'(NOP_INSTR);
                instr_valid <= 1'b0;
                jump_addr   <= '0;
                branch_addr <= '0;
            end else if (state == WAIT && done) begin
                instr_out   <= load_word;
                instr_pc    <= imem_addr;
                instr_valid <= 1'b1;
                jump_addr   <= dec_jump;
                branch_addr <= dec_branch;
            end else if (state == FULL && !stall) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage: directed scenarios followed by a randomized run
// against a transaction-level model of the fetch stage.
module tb_instr_fetch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] pc_addr;
    logic        pc_valid;
    logic        pc_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic [25:0] jump_addr;
    logic [31:0] branch_addr;
    logic        fetch_error;

    int checks = 0;
    int errors = 0;

    instr_fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .pc_addr     (pc_addr),
        .pc_valid    (pc_valid),
        .pc_ready    (pc_ready),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .flush       (flush),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .jump_addr   (jump_addr),
        .branch_addr (branch_addr),
        .fetch_error (fetch_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] exp_branch(input logic [31:0] w);
        int s;
        s = int'(w & 32'h0000_FFFF);
        if (s >= 32768) s = s - 65536;
        return 32'(s * 4);
    endfunction

    function automatic logic [31:0] exp_jump(input logic [31:0] w);
        return w & 32'h03FF_FFFF;
    endfunction

    bit          pending;
    bit          discard;
    bit          held;
    bit          ready_e;
    logic [31:0] cur;
    int          lat;

    initial begin
        clk        = 1'b0;
        reset      = 1'b1;
        pc_addr    = '0;
        pc_valid   = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        stall      = 1'b0;
        flush      = 1'b0;

        // Reset values
        #3;
        chk("rst_ready", pc_ready, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr_out, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_err", fetch_error, 0);
        @(negedge clk);
        reset = 1'b0;

        // Zero-latency ack, negative branch displacement
        pc_addr  = 32'h4;
        pc_valid = 1'b1;
        #1 chk("t1_ready", pc_ready, 1);
        @(negedge clk);
        pc_valid   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h1000_FFFF;
        #1 chk("t1_req", imem_req, 1);
        chk("t1_addr", imem_addr, 32'h4);
        chk("t1_valid_early", instr_valid, 0);
        @(negedge clk);
        imem_ack = 1'b0;
        #1 chk("t1_valid", instr_valid, 1);
        chk("t1_instr", instr_out, 32'h1000_FFFF);
        chk("t1_pc", instr_pc, 32'h4);
        chk("t1_branch", branch_addr, 32'hFFFF_FFFC);
        chk("t1_jump", jump_addr, 32'h0000_FFFF);
        @(negedge clk);
        #1 chk("t1_consumed", instr_valid, 0);
        chk("t1_idle_ready", pc_ready, 1);

        // Latency 3, then stall held for 4 cycles
        pc_addr  = 32'h100;
        pc_valid = 1'b1;
        stall    = 1'b1;
        #1 chk("t2_ready", pc_ready, 1);
        @(negedge clk);
        pc_addr = 32'h104;
        #1 chk("t2_req0", imem_req, 1);
        chk("t2_addr0", imem_addr, 32'h100);
        chk("t2_ready_wait", pc_ready, 0);
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            #1 chk("t2_req", imem_req, 1);
            chk("t2_addr", imem_addr, 32'h100);
        end
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0800_0040;
        #1 chk("t2_addr_ack", imem_addr, 32'h100);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            imem_ack = 1'b0;
            #1 chk("t2_hold_valid", instr_valid, 1);
            chk("t2_hold_instr", instr_out, 32'h0800_0040);
            chk("t2_hold_ready", pc_ready, 0);
            chk("t2_jump", jump_addr, 32'h0000_0040);
            chk("t2_branch", branch_addr, 32'h0000_0100);
        end
        @(negedge clk);
        stall = 1'b0;
        #1 chk("t2_release_ready", pc_ready, 1);
        @(negedge clk);
        pc_valid = 1'b0;
        #1 chk("t2_next_valid", instr_valid, 0);
        chk("t2_next_req", imem_req, 1);
        chk("t2_next_addr", imem_addr, 32'h104);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_8000;

        // Flush while FULL and stalled
        @(negedge clk);
        imem_ack = 1'b0;
        stall    = 1'b1;
        flush    = 1'b1;
        pc_valid = 1'b1;
        pc_addr  = 32'h108;
        #1 chk("t2b_pc", instr_pc, 32'h104);
        chk("t2b_branch", branch_addr, 32'hFFFE_0000);
        chk("t2b_flush_ready", pc_ready, 0);
        @(negedge clk);
        flush    = 1'b0;
        pc_valid = 1'b0;
        stall    = 1'b0;
        #1 chk("t2b_valid", instr_valid, 0);
        chk("t2b_nop", instr_out, 32'h0);
        chk("t2b_no_req", imem_req, 0);
        chk("t2b_ready", pc_ready, 1);

        // Flush in WAIT before ack: drain then idle
        pc_addr  = 32'h200;
        pc_valid = 1'b1;
        @(negedge clk);
        pc_addr = 32'h204;
        flush   = 1'b1;
        #1 chk("t3_flush_ready", pc_ready, 0);
        chk("t3_req", imem_req, 1);
        @(negedge clk);
        flush = 1'b0;
        #1 chk("t3_drain_req", imem_req, 1);
        chk("t3_drain_ready", pc_ready, 0);
        chk("t3_drain_valid", instr_valid, 0);
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1 chk("t3_ack_req", imem_req, 1);
        chk("t3_ack_valid", instr_valid, 0);
        @(negedge clk);
        imem_ack = 1'b0;
        pc_valid = 1'b0;
        #1 chk("t3_idle_valid", instr_valid, 0);
        chk("t3_idle_req", imem_req, 0);
        chk("t3_idle_ready", pc_ready, 1);

        // Flush coincident with ack
        pc_addr  = 32'h300;
        pc_valid = 1'b1;
        @(negedge clk);
        pc_valid   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        flush      = 1'b1;
        #1 chk("t3b_req", imem_req, 1);
        @(negedge clk);
        imem_ack = 1'b0;
        flush    = 1'b0;
        #1 chk("t3b_valid", instr_valid, 0);
        chk("t3b_nop", instr_out, 32'h0);
        chk("t3b_req_off", imem_req, 0);
        chk("t3b_ready", pc_ready, 1);

        // Asynchronous reset mid-WAIT
        pc_addr  = 32'h400;
        pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0;
        #1 chk("t4_req", imem_req, 1);
        chk("t4_addr", imem_addr, 32'h400);
        #2 reset = 1'b1;
        #1 chk("t4_async_req", imem_req, 0);
        chk("t4_async_addr", imem_addr, 32'h0);
        chk("t4_async_ready", pc_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("t4_ready", pc_ready, 1);
        chk("t4_valid", instr_valid, 0);

        // No ack at all
        pc_addr  = 32'h500;
        pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            #1 chk("t5_req", imem_req, 1);
            chk("t5_err", fetch_error, 0);
        end
        @(negedge clk);
        #1 chk("t5_req_drop", imem_req, 0);
        chk("t5_err_pulse", fetch_error, 1);
        @(negedge clk);
        #1 chk("t5_valid", instr_valid, 1);
        chk("t5_nop", instr_out, 32'h0);
        chk("t5_pc", instr_pc, 32'h500);
        chk("t5_err_end", fetch_error, 0);
        chk("t5_req_end", imem_req, 0);
`else
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            #1 chk("t5_req", imem_req, 1);
            chk("t5_err", fetch_error, 0);
        end
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_7FFF;
        @(negedge clk);
        imem_ack = 1'b0;
        #1 chk("t5_valid", instr_valid, 1);
        chk("t5_branch", branch_addr, 32'h0001_FFFC);
`endif

        // Randomized run against the transaction model
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        pending = 1'b0;
        discard = 1'b0;
        held    = 1'b0;
        cur     = '0;
        lat     = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            stall    = ($urandom_range(0, 2) == 0);
            flush    = ($urandom_range(0, 15) == 0);
            pc_valid = ($urandom_range(0, 3) != 0);
            pc_addr  = $urandom & 32'hFFFF_FFFC;
            if (pending) begin
                imem_ack = (lat == 0);
                if (lat > 0) lat--;
                imem_rdata = imem_ack ? mem_word(cur) : $urandom;
            end else begin
                imem_ack   = ($urandom_range(0, 7) == 0);
                imem_rdata = $urandom;
            end
            ready_e = !flush && !pending && (!held || !stall);
            #1 chk("r_ready", pc_ready, ready_e);
            chk("r_valid", instr_valid, held);
            chk("r_req", imem_req, pending);
            chk("r_err", fetch_error, 0);
            if (pending) chk("r_addr", imem_addr, cur);
            if (held) begin
                chk("r_pc", instr_pc, cur);
                chk("r_instr", instr_out, mem_word(cur));
                chk("r_jump", jump_addr, exp_jump(mem_word(cur)));
                chk("r_branch", branch_addr, exp_branch(mem_word(cur)));
            end
            if (flush) begin
                held = 1'b0;
                if (pending) begin
                    if (imem_ack) begin
                        pending = 1'b0;
                        discard = 1'b0;
                    end else begin
                        discard = 1'b1;
                    end
                end
            end else begin
                if (held && !stall) held = 1'b0;
                if (pending && imem_ack) begin
                    pending = 1'b0;
                    held    = !discard;
                    discard = 1'b0;
                end
            end
            if (ready_e && pc_valid) begin
                pending = 1'b1;
                cur     = pc_addr;
                lat     = $urandom_range(0, 3);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
